ram_cmd_initiator: RTL

- Initiator for the 10-bit RAM command interface. It is the block that drives rx_data/rx_valid into the RAM and consumes tx_data/tx_valid coming back.
- Converts single read or write requests from a valid/ready request port into the 2-word RAM command sequence, then returns one response per request.
- Sits between the test or system controller and the RAM. Replaces ad-hoc command sequencing in benches and top levels.

---
 rtl/ram_cmd_pkg.sv | 24 ++
 rtl/ram_cmd_timer.sv | 22 ++
 rtl/ram_cmd_initiator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_cmd_pkg.sv
// Shared types and constants for the RAM command initiator.
package ram_cmd_pkg;
  localparam int CMD_W = 2;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND_ADDR,
    GAP,
    SEND_DATA,
    WAIT_RSP,
    RESP
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ram_cmd_timer.sv
// Loadable down-counter shared by the inter-word gap and the read-response timeout.
module ram_cmd_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  // done marks the last cycle of the loaded window
  assign done = (cnt <= W'(1));
endmodule

// File: rtl/ram_cmd_initiator.sv
// Turns single read/write requests into the 2-word RAM command sequence and returns one response.
// Optional address cache enabled by defining RAM_CMD_ADDR_CACHE_EN.
module ram_cmd_initiator
  import ram_cmd_pkg::*;
#(
  parameter int MEM_WIDTH  = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [ADDR_SIZE-1:0]   req_addr,
  input  logic [MEM_WIDTH-1:0]   req_wdata,
  output logic                   rsp_valid,
  output logic [MEM_WIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_SIZE+1:0]   rx_data,
  output logic                   rx_valid,
  input  logic [MEM_WIDTH-1:0]   tx_data,
  input  logic                   tx_valid,
  output logic                   busy
);
  localparam int TMAX = max_int(GAP_CYCLES, TIMEOUT);
  localparam int TW   = $clog2(TMAX + 1);

  if (MEM_WIDTH != ADDR_SIZE) begin : g_bad_width
    $error("ram_cmd_initiator: MEM_WIDTH must equal ADDR_SIZE");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("ram_cmd_initiator: GAP_CYCLES out of range 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("ram_cmd_initiator: TIMEOUT out of range 1..255");
  end

  state_t                 state, nxt;
  logic                   cap_wr;
  logic [ADDR_SIZE-1:0]   cap_addr;
  logic [MEM_WIDTH-1:0]   cap_wdata;
  logic                   cur_wr;
  logic [ADDR_SIZE-1:0]   cur_addr;
  logic [MEM_WIDTH-1:0]   cur_wdata;
  logic [CMD_W-1:0]       addr_cmd, data_cmd;
  logic                   hit;
  logic                   tmr_load, tmr_dec, tmr_done;
  logic [TW-1:0]          tmr_val;

  // Outputs are computed on the handshake edge, before the capture registers are loaded.
  assign cur_wr    = (state == IDLE) ? req_wr    : cap_wr;
  assign cur_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;
  assign addr_cmd  = cur_wr ? CMD_WR_ADDR : CMD_RD_ADDR;
  assign data_cmd  = cur_wr ? CMD_WR_DATA : CMD_RD_DATA;

`ifdef RAM_CMD_ADDR_CACHE_EN
  logic                 last_wr_vld, last_rd_vld;
  logic [ADDR_SIZE-1:0] last_wr_addr, last_rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr_vld  <= 1'b0;
      last_rd_vld  <= 1'b0;
      last_wr_addr <= '0;
      last_rd_addr <= '0;
    end else if (nxt == SEND_ADDR) begin
      if (cur_wr) begin
        last_wr_vld  <= 1'b1;
        last_wr_addr <= cur_addr;
      end else begin
        last_rd_vld  <= 1'b1;
        last_rd_addr <= cur_addr;
      end
    end
  end

  assign hit = req_wr ? (last_wr_vld && last_wr_addr == req_addr)
                      : (last_rd_vld && last_rd_addr == req_addr);
`else
  assign hit = 1'b0;
`endif

  ram_cmd_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state)
      IDLE:      if (req_valid) nxt = hit ? SEND_DATA : SEND_ADDR;
      SEND_ADDR: begin
        if (GAP_CYCLES > 0) begin
          nxt      = GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYCLES);
        end else begin
          nxt = SEND_DATA;
        end
      end
      GAP: begin
        tmr_dec = 1'b1;
        if (tmr_done) nxt = SEND_DATA;
      end
      SEND_DATA: begin
        if (cap_wr) begin
          nxt = RESP;
        end else begin
          nxt      = WAIT_RSP;
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT);
        end
      end
      WAIT_RSP: begin
        tmr_dec = 1'b1;
        if (tx_valid || tmr_done) nxt = RESP;
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state == IDLE && req_valid) begin
      cap_wr    <= req_wr;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // Registered outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= (nxt == IDLE);
      busy      <= (nxt != IDLE);
      rx_valid  <= (nxt == SEND_ADDR) || (nxt == SEND_DATA);
      rsp_valid <= (nxt == RESP);
      if (nxt == SEND_ADDR)      rx_data <= {addr_cmd, cur_addr};
      else if (nxt == SEND_DATA) rx_data <= {data_cmd, cur_wr ? cur_wdata : '0};
      if (nxt == RESP) begin
        rsp_rdata <= (state == WAIT_RSP && tx_valid) ? tx_data : '0;
        rsp_err   <= (state == WAIT_RSP) && !tx_valid;
      end
    end
  end
endmodule
